tl_sensor_cond: RTL and testbench
=================================

// Module: tl_sensor_cond
// PURPOSE
//  Upstream conditioning stage for the left-turn traffic-light controller.
//  Takes the four raw, asynchronous vehicle-sensor inputs and produces clean, registered
//  ta/tal/tb/tbl levels. The next-state logic consumes these levels directly.
//  Per channel: 2-flop synchronizer, symmetric debounce, minimum-on hold.
//  This stops sensor chatter from toggling the green/left-green dwell decision.
// PARAMETERS
//  DB_CYCLES  4  consecutive stable synchronized cycles required before an output edge (1..2^CNT_W-1)
//  HOLD_CYCLES 8  minimum cycles an output stays 1 once asserted (0 = no hold; 0..2^CNT_W-1)
//  CNT_W      4  width of each per-channel counter
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  reset_n  in   1  asynchronous, active-low reset
//  ta_raw   in   1  raw street-A through sensor (async)
//  tal_raw  in   1  raw street-A left-turn sensor (async)
//  tb_raw   in   1  raw street-B through sensor (async)
//  tbl_raw  in   1  raw street-B left-turn sensor (async)
//  ta       out  1  conditioned A through traffic present
//  tal      out  1  conditioned A left traffic present
//  tb       out  1  conditioned B through traffic present
//  tbl      out  1  conditioned B left traffic present
// BEHAVIOUR
//  Reset: async on reset_n=0. All sync flops, counters and outputs go to 0. Every channel FSM goes to OFF.
//   Reset mid-debounce or mid-hold discards progress. Outputs read 0 in the same cycle reset asserts.
//  Sync: s = 2-flop register of x_raw. The FSM sees s only, never x_raw.
//  Channels are identical and independent. Simultaneous activity on all four channels has no interaction.
//  Per-channel FSM (cnt is CNT_W bits, out registered):
//   OFF   : out=0. If s=1, go to RISE with cnt=1. Otherwise stay.
//   RISE  : out=0. If s=0, go to OFF with cnt=0.
//           Else if cnt==DB_CYCLES, go to HOLD (or ON when HOLD_CYCLES=0) with out<=1 and cnt=0.
//           Else cnt++.
//   HOLD  : out=1 and s is ignored. cnt++.
//           When cnt==HOLD_CYCLES-1, go to ON with cnt=0.
//   ON    : out=1. If s=0, go to FALL with cnt=1. Otherwise stay.
//   FALL  : out=1. If s=1, go to ON with cnt=0.
//           Else if cnt==DB_CYCLES, go to OFF with out<=0 and cnt=0.
//           Else cnt++.
//  Latency:
//   A clean raw rise appears on out after 2 sync cycles + DB_CYCLES cycles. Default is 6 cycles after the first sampling edge.
//   A clean fall appears after the same latency, measured from the later of the raw fall and the hold expiry.
//  Glitch rule:
//   Any synchronized pulse shorter than DB_CYCLES cycles never reaches out.
//   A single-cycle gap in ON returns to ON with no output change.
//  Counters never wrap. Each saturates by construction at DB_CYCLES or HOLD_CYCLES-1, both less than 2^CNT_W.
//  Outputs are glitch-free flops. No combinational path from any raw input to any output.
//  Unused or illegal FSM encodings recover to OFF with out=0 on the next clock.
// TESTING
//  1. Reset: hold reset_n=0 with all raw=1 for 10 cycles. All outputs are 0.
//     Release reset. ta rises exactly 6 cycles after the first clk edge with reset_n=1.
//  2. Glitch reject: with ta_raw=0, pulse ta_raw=1 for 3 clk cycles (DB=4). ta stays 0 throughout and for 10 cycles after.
//  3. Hold: assert tb_raw for 5 cycles, then drop it. tb=1 for at least 8 cycles.
//     tb falls 4 debounce cycles after hold expiry, 12 cycles after the rise.
//  4. Chatter while ON: tal_raw=1 steady past hold, then a 1-cycle 0 dropout every 3 cycles for 30 cycles. tal stays 1.
//  5. Independence: toggle all four raw inputs with different phases. Each output matches a single-channel golden model cycle-for-cycle.
//  6. Mid-operation reset: pull reset_n low asynchronously (between edges) while tbl is in HOLD and while ta is in RISE.
//     Both outputs go to 0 immediately. After release, a full 6-cycle re-qualification is required.

Source files
------------

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning for the left-turn traffic-light controller: per-channel
// 2-flop sync, symmetric debounce and minimum-on hold for ta/tal/tb/tbl.
module tl_sensor_cond #(
   parameter int unsigned DB_CYCLES   = 4,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ta_raw,
   input  logic tal_raw,
   input  logic tb_raw,
   input  logic tbl_raw,
   output logic ta,
   output logic tal,
   output logic tb,
   output logic tbl
);

   localparam int unsigned NCH = 4;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_RISE = 3'd1,
      ST_HOLD = 3'd2,
      ST_ON   = 3'd3,
      ST_FALL = 3'd4
   } state_e;

   logic [NCH-1:0] raw_c;
   logic [NCH-1:0] cond_c;

   assign raw_c = {tbl_raw, tb_raw, tal_raw, ta_raw};

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic             meta_q;
      logic             sync_q;
      logic             out_q;
      logic             out_d;
      state_e           state_q;
      state_e           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic [CNT_W-1:0] cnt_inc_c;

      assign cnt_inc_c = cnt_q + CNT_W'(1);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            out_q   <= 1'b0;
            state_q <= ST_OFF;
            cnt_q   <= '0;
         end else begin
            meta_q  <= raw_c[g];
            sync_q  <= meta_q;
            out_q   <= out_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Debounce/hold decision; only the synchronized level is ever consulted.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         out_d   = out_q;
         case (state_q)
            ST_OFF: begin
               out_d = 1'b0;
               if (sync_q) begin
                  state_d = ST_RISE;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_RISE: begin
               out_d = 1'b0;
               if (!sync_q) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = (HOLD_CYCLES == 0) ? ST_ON : ST_HOLD;
                  out_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            ST_HOLD: begin
               out_d = 1'b1;
               if (cnt_inc_c >= HOLD_LAST) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            ST_ON: begin
               out_d = 1'b1;
               if (!sync_q) begin
                  state_d = ST_FALL;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_FALL: begin
               out_d = 1'b1;
               if (sync_q) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = ST_OFF;
                  out_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            default: begin
               state_d = ST_OFF;
               out_d   = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end

      assign cond_c[g] = out_q;
   end

   assign ta  = cond_c[0];
   assign tal = cond_c[1];
   assign tb  = cond_c[2];
   assign tbl = cond_c[3];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: run-length reference model checked every cycle,
// plus directed scenarios with hand-derived timing.
module tb_tl_sensor_cond;

   localparam int DB   = 4;
   localparam int HOLD = 8;
   // The hold phase ends on the edge its count reaches HOLD-1 (at least one edge).
   localparam int HOLD_EDGES = (HOLD == 0) ? 0 : ((HOLD <= 2) ? 1 : HOLD - 1);

   logic clk = 1'b0;
   logic reset_n;
   logic ta_raw, tal_raw, tb_raw, tbl_raw;
   logic ta, tal, tb, tbl;

   int total = 0;
   int bad   = 0;

   tl_sensor_cond #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ta_raw  (ta_raw),
      .tal_raw (tal_raw),
      .tb_raw  (tb_raw),
      .tbl_raw (tbl_raw),
      .ta      (ta),
      .tal     (tal),
      .tb      (tb),
      .tbl     (tbl)
   );

   always #5 clk = ~clk;

   logic [3:0] raw_v;
   logic [3:0] dut_v;
   assign raw_v = {tbl_raw, tb_raw, tal_raw, ta_raw};
   assign dut_v = {tbl, tb, tal, ta};

   // Model: two-sample delay, then an output flips after DB+1 consecutive
   // disagreeing samples; a rise freezes the output for the hold phase.
   logic [3:0] m_meta = '0;
   logic [3:0] m_s    = '0;
   logic [3:0] m_out  = '0;
   int         m_run  [4] = '{0, 0, 0, 0};
   int         m_hold [4] = '{0, 0, 0, 0};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_meta <= '0;
         m_s    <= '0;
         m_out  <= '0;
         for (int ch = 0; ch < 4; ch++) begin
            m_run[ch]  <= 0;
            m_hold[ch] <= 0;
         end
      end else begin
         m_meta <= raw_v;
         m_s    <= m_meta;
         for (int ch = 0; ch < 4; ch++) begin
            if (m_hold[ch] > 0) begin
               m_hold[ch] <= m_hold[ch] - 1;
               m_run[ch]  <= 0;
            end else if (m_s[ch] != m_out[ch]) begin
               if (m_run[ch] == DB) begin
                  m_out[ch]  <= ~m_out[ch];
                  m_run[ch]  <= 0;
                  m_hold[ch] <= m_out[ch] ? 0 : HOLD_EDGES;
               end else begin
                  m_run[ch] <= m_run[ch] + 1;
               end
            end else begin
               m_run[ch] <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int ch = 0; ch < 4; ch++) begin
         total++;
         if (dut_v[ch] !== m_out[ch]) begin
            bad++;
            $display("FAIL model ch%0d t=%0t: dut=%b model=%b", ch, $time, dut_v[ch], m_out[ch]);
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got=%b want=%b", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_raw(input logic [3:0] v);
      {tbl_raw, tb_raw, tal_raw, ta_raw} = v;
   endtask

   int len [4];

   initial begin
      reset_n = 1'b0;
      set_raw(4'hF);

      // Reset with all sensors active, then full qualification latency.
      tick(10);
      check("reset_ta", ta, 1'b0);
      check("reset_tal", tal, 1'b0);
      check("reset_tb", tb, 1'b0);
      check("reset_tbl", tbl, 1'b0);
      reset_n = 1'b1;
      tick(6);
      check("rise_ta_early", ta, 1'b0);
      tick(1);
      check("rise_ta_edge7", ta, 1'b1);
      check("rise_tal_edge7", tal, 1'b1);
      check("rise_tb_edge7", tb, 1'b1);
      check("rise_tbl_edge7", tbl, 1'b1);
      set_raw(4'h0);
      tick(30);
      check("settle_ta", ta, 1'b0);
      check("settle_tbl", tbl, 1'b0);

      // Glitch shorter than the debounce window.
      ta_raw = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if (i == 3) ta_raw = 1'b0;
         tick(1);
         check("glitch_ta", ta, 1'b0);
      end

      // Short tb pulse stretched by hold: rise at edge 7, fall at edge 19.
      tb_raw = 1'b1;
      tick(5);
      tb_raw = 1'b0;
      tick(1);
      check("hold_tb_pre", tb, 1'b0);
      tick(1);
      check("hold_tb_rise", tb, 1'b1);
      for (int i = 8; i <= 18; i++) begin
         tick(1);
         check("hold_tb_high", tb, 1'b1);
      end
      tick(1);
      check("hold_tb_fall", tb, 1'b0);
      tick(10);

      // Single-cycle dropouts while ON.
      tal_raw = 1'b1;
      tick(25);
      check("chatter_tal_on", tal, 1'b1);
      for (int i = 0; i < 30; i++) begin
         tal_raw = (i % 3 == 2) ? 1'b0 : 1'b1;
         tick(1);
         check("chatter_tal", tal, 1'b1);
      end
      tal_raw = 1'b0;
      tick(25);
      check("chatter_tal_off", tal, 1'b0);

      // Independent random runs on all channels.
      for (int ch = 0; ch < 4; ch++) len[ch] = $urandom_range(1, 12);
      for (int i = 0; i < 800; i++) begin
         for (int ch = 0; ch < 4; ch++) begin
            len[ch]--;
            if (len[ch] == 0) begin
               case (ch)
                  0: ta_raw  = ~ta_raw;
                  1: tal_raw = ~tal_raw;
                  2: tb_raw  = ~tb_raw;
                  default: tbl_raw = ~tbl_raw;
               endcase
               len[ch] = $urandom_range(1, 12);
            end
         end
         tick(1);
      end
      set_raw(4'h0);
      tick(40);

      // Asynchronous reset while tbl holds and ta is still debouncing.
      tbl_raw = 1'b1;
      tick(4);
      ta_raw = 1'b1;
      tick(5);
      check("midrst_tbl_hold", tbl, 1'b1);
      check("midrst_ta_rise", ta, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_tbl_zero", tbl, 1'b0);
      check("midrst_ta_zero", ta, 1'b0);
      tick(3);
      reset_n = 1'b1;
      tick(6);
      check("requal_ta_early", ta, 1'b0);
      check("requal_tbl_early", tbl, 1'b0);
      tick(1);
      check("requal_ta", ta, 1'b1);
      check("requal_tbl", tbl, 1'b1);
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
